// File: rtl/div_share_pkg.sv
// Shared types and constants for the two-port divider share controller.
package div_share_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FAST,
    ISSUE,
    BUSY,
    ABORT,
    RESP
  } state_e;

  localparam logic [2:0]  F3_DIV    = 3'b100;
  localparam logic [2:0]  F3_DIVU   = 3'b101;
  localparam logic [2:0]  F3_REM    = 3'b110;
  localparam logic [2:0]  F3_REMU   = 3'b111;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE   = 32'hFFFF_FFFF;

  // Divide-by-zero and signed overflow are resolved without the divider.
  function automatic logic is_fast_op(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [2:0]  f3);
    return (b == '0) || (!f3[0] && (a == INT_MIN) && (b == NEG_ONE));
  endfunction

  // funct3[1] selects remainder over quotient.
  function automatic logic [31:0] fast_result(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [2:0]  f3);
    if (b == '0) return f3[1] ? a : DIV0_QUOT;
    else         return f3[1] ? '0 : INT_MIN;
  endfunction

endpackage

// File: rtl/div_share_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the preferred requester.
module rr_arbiter2
  import div_share_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] request,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;

  // Pick the pointed-to requester when both ask, otherwise the lone one.
  always_comb begin
    grant = request;
    if (request == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
  end

  // After a grant the pointer moves to the requester that was not served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ptr_q <= 1'b0;
    else if (advance) ptr_q <= grant[0];
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative divider between two requesters, with a fast path for
// divide-by-zero / signed overflow and per-owner flush.
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][31:0] req_b,
  input  logic [NREQ-1:0][2:0]  req_funct3,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       flush,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  div_valid,
  output logic                  div_flush,
  output logic [31:0]           div_a,
  output logic [31:0]           div_b,
  output logic [2:0]            div_funct3,
  input  logic [31:0]           div_res,
  input  logic                  div_done
);

  state_e      state_q;
  logic [31:0] a_q, b_q, res_q, rsp_data_q;
  logic [2:0]  f3_q;
  logic        owner_q;

  logic [NREQ-1:0] arb_req, grant;
  logic            arb_adv, gnt_id, own_flush, rsp_go;
  logic [31:0]     sel_a, sel_b;
  logic [2:0]      sel_f3;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .request (arb_req),
    .advance (arb_adv),
    .grant   (grant)
  );

  // Arbitration only in IDLE; a requester flushing itself is not eligible.
  always_comb begin
    arb_req = (state_q == IDLE) ? (req_valid & ~flush) : '0;
    arb_adv = |grant;
    gnt_id  = grant[1];
    sel_a   = req_a[gnt_id];
    sel_b   = req_b[gnt_id];
    sel_f3  = req_funct3[gnt_id];
  end

  // Output decode from state and owner, gated by the owner's flush.
  always_comb begin
    own_flush  = flush[owner_q];
    rsp_go     = ((state_q == FAST) || (state_q == RESP)) && !own_flush;
    req_ready  = grant & {NREQ{reset}};
    rsp_valid  = '0;
    if (rsp_go) rsp_valid[owner_q] = 1'b1;
    // Result appears combinationally with the pulse, otherwise the last one holds.
    rsp_data   = rsp_go ? res_q : rsp_data_q;
    div_valid  = (state_q == ISSUE) && !own_flush;
    div_flush  = ((state_q == ISSUE) || (state_q == BUSY)) && own_flush;
    div_a      = a_q;
    div_b      = b_q;
    div_funct3 = f3_q;
  end

  // Controller FSM and operand/result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      f3_q       <= '0;
      owner_q    <= 1'b0;
      res_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            f3_q    <= sel_f3;
            owner_q <= gnt_id;
            if (is_fast_op(sel_a, sel_b, sel_f3)) begin
              res_q   <= fast_result(sel_a, sel_b, sel_f3);
              state_q <= FAST;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: state_q <= own_flush ? ABORT : BUSY;
        BUSY: begin
          if (own_flush) begin
            state_q <= ABORT;
          end else if (div_done) begin
            res_q   <= div_res;
            state_q <= RESP;
          end
        end
        ABORT: state_q <= IDLE;
        FAST, RESP: begin
          if (rsp_go) rsp_data_q <= res_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench: the bench plays both requesters and the divider.
module tb_div_share_ctrl;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_a, req_b;
  logic [1:0][2:0]  req_funct3;
  logic [1:0]       req_ready;
  logic [1:0]       flush;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_data;
  logic             div_valid, div_flush;
  logic [31:0]      div_a, div_b;
  logic [2:0]       div_funct3;
  logic [31:0]      div_res;
  logic             div_done;

  int total = 0;
  int bad   = 0;

  logic [31:0] ta [2];
  logic [31:0] tb [2];
  logic [2:0]  tf [2];
  logic [1:0]  pend;
  int          ptr_m;
  logic [31:0] last_rsp;

  div_share_ctrl #(.NREQ(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_funct3 (req_funct3),
    .req_ready  (req_ready),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .div_valid  (div_valid),
    .div_flush  (div_flush),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_funct3 (div_funct3),
    .div_res    (div_res),
    .div_done   (div_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RISC-V M-extension semantics from plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
    if (f3[0]) return f3[1] ? (a % b) : (a / b);
    return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic bit ref_fast(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] f3);
    return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    req_valid = pend;
    for (int i = 0; i < 2; i++) begin
      req_a[i]      = ta[i];
      req_b[i]      = tb[i];
      req_funct3[i] = tf[i];
    end
  endtask

  task automatic gen_normal(input int i);
    ta[i] = $urandom;
    tb[i] = $urandom | 32'd1;
    if (tb[i] == 32'hFFFF_FFFF) tb[i] = 32'd3;
    tf[i] = 3'(4 + $urandom_range(0, 3));
    pend[i] = 1'b1;
  endtask

  task automatic gen_any(input int i);
    gen_normal(i);
    case ($urandom_range(0, 7))
      0: tb[i] = 32'd0;
      1: begin ta[i] = 32'h8000_0000; tb[i] = 32'hFFFF_FFFF; tf[i] = $urandom_range(0, 1) ? 3'b100 : 3'b110; end
      default: ;
    endcase
  endtask

  // Cycle T: expect the round-robin winner's accept pulse; leaves the bench at T+1.
  task automatic do_grant(output int w);
    logic [1:0] exp_rdy;
    drive_reqs();
    #1;
    w = (pend == 2'b11) ? ptr_m : (pend[1] ? 1 : 0);
    exp_rdy = 2'b01 << w;
    total++;
    if (req_ready !== exp_rdy) begin
      bad++;
      $display("FAIL grant: req_ready=%b expected=%b", req_ready, exp_rdy);
    end
    total++;
    if (rsp_valid !== 2'b00 || rsp_data !== last_rsp) begin
      bad++;
      $display("FAIL idle_hold: rsp_valid=%b rsp_data=%h expected 00/%h", rsp_valid, rsp_data, last_rsp);
    end
    pend[w] = 1'b0;
    ptr_m = 1 - w;
    next_cycle();
    drive_reqs();
  endtask

  // From T+1: check fast or divider path, respond after 'delay' busy cycles.
  task automatic do_complete(input int w, input int delay, input int fo_cyc);
    logic [31:0] exp, ea, eb;
    logic [2:0]  ef;
    logic [1:0]  exp_v;
    ea = ta[w]; eb = tb[w]; ef = tf[w];
    exp = ref_res(ea, eb, ef);
    exp_v = 2'b01 << w;
    #1;
    if (ref_fast(ea, eb, ef)) begin
      total++;
      if (rsp_valid !== exp_v || rsp_data !== exp || div_valid !== 1'b0 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL fast_rsp: rsp_valid=%b rsp_data=%h div_valid=%b req_ready=%b expected %b/%h/0/00",
                 rsp_valid, rsp_data, div_valid, req_ready, exp_v, exp);
      end
      last_rsp = exp;
    end else begin
      total++;
      if (div_valid !== 1'b1 || div_flush !== 1'b0 || div_a !== ea || div_b !== eb ||
          div_funct3 !== ef || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL issue: div_valid=%b div_flush=%b a=%h b=%h f3=%b rsp_valid=%b req_ready=%b expected 1/0/%h/%h/%b/00/00",
                 div_valid, div_flush, div_a, div_b, div_funct3, rsp_valid, req_ready, ea, eb, ef);
      end
      for (int k = 0; k < delay; k++) begin
        next_cycle();
        flush = 2'b00;
        if (k == fo_cyc) flush[1-w] = 1'b1;
        #1;
        total++;
        if (div_valid !== 1'b0 || div_flush !== 1'b0 || rsp_valid !== 2'b00 ||
            req_ready !== 2'b00 || rsp_data !== last_rsp) begin
          bad++;
          $display("FAIL busy: div_valid=%b div_flush=%b rsp_valid=%b req_ready=%b rsp_data=%h expected 0/0/00/00/%h",
                   div_valid, div_flush, rsp_valid, req_ready, rsp_data, last_rsp);
        end
      end
      next_cycle();
      flush    = 2'b00;
      div_done = 1'b1;
      div_res  = exp;
      #1;
      total++;
      if (rsp_valid !== 2'b00 || div_flush !== 1'b0) begin
        bad++;
        $display("FAIL done_cycle: rsp_valid=%b div_flush=%b expected 00/0", rsp_valid, div_flush);
      end
      next_cycle();
      div_done = 1'b0;
      div_res  = $urandom;
      #1;
      total++;
      if (rsp_valid !== exp_v || rsp_data !== exp) begin
        bad++;
        $display("FAIL resp: rsp_valid=%b rsp_data=%h expected %b/%h", rsp_valid, rsp_data, exp_v, exp);
      end
      last_rsp = exp;
    end
    next_cycle();
    req_valid = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pend = 2'b11;
    gen_normal(0);
    gen_normal(1);
    drive_reqs();
    flush = 2'b00; div_done = 1'b0; div_res = 32'hDEAD_BEEF;
    #2;
    total++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || div_valid !== 1'b0 || div_flush !== 1'b0 ||
        rsp_data !== 32'd0 || div_a !== 32'd0 || div_b !== 32'd0 || div_funct3 !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b rv=%b dv=%b df=%b rd=%h a=%h b=%h f3=%b expected all zero",
               req_ready, rsp_valid, div_valid, div_flush, rsp_data, div_a, div_b, div_funct3);
    end
    pend = 2'b00;
    drive_reqs();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    ptr_m = 0;
    last_rsp = 32'd0;
  endtask

  task automatic test_normal();
    int w;
    ta[0] = 32'd100; tb[0] = 32'd7; tf[0] = 3'b100; pend = 2'b01;
    do_grant(w);
    do_complete(w, 3, -1);
    total++;
    if (last_rsp !== 32'd14 || rsp_data !== 32'd14) begin
      bad++;
      $display("FAIL div_100_7: rsp_data=%h expected 0000000e", rsp_data);
    end
  endtask

  task automatic test_fast();
    int w;
    ta[1] = 32'hFFFF_FFF9; tb[1] = 32'd0; tf[1] = 3'b110; pend = 2'b10;
    do_grant(w);
    do_complete(w, 0, -1);
    ta[0] = 32'h8000_0000; tb[0] = 32'hFFFF_FFFF; tf[0] = 3'b100; pend = 2'b01;
    do_grant(w);
    do_complete(w, 0, -1);
  endtask

  task automatic test_fast_flush();
    int w;
    ta[0] = 32'h1234_5678; tb[0] = 32'd0; tf[0] = 3'b101; pend = 2'b01;
    do_grant(w);
    flush[w] = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 2'b00 || rsp_data !== last_rsp || div_valid !== 1'b0) begin
      bad++;
      $display("FAIL fast_flush: rsp_valid=%b rsp_data=%h div_valid=%b expected 00/%h/0",
               rsp_valid, rsp_data, div_valid, last_rsp);
    end
    next_cycle();
    flush = 2'b00;
    req_valid = 2'b00;
  endtask

  task automatic test_back_to_back();
    int w;
    gen_normal(0);
    gen_normal(1);
    for (int i = 0; i < 4; i++) begin
      do_grant(w);
      do_complete(w, $urandom_range(0, 3), -1);
      gen_normal(w);
    end
    pend = 2'b00;
  endtask

  task automatic test_flush_owner();
    int w;
    gen_normal(0);
    tf[0] = 3'b101;
    pend = 2'b01;
    do_grant(w);
    gen_normal(1);
    drive_reqs();
    #1;
    total++;
    if (div_valid !== 1'b1 || req_ready !== 2'b00) begin
      bad++;
      $display("FAIL flush_issue: div_valid=%b req_ready=%b expected 1/00", div_valid, req_ready);
    end
    next_cycle();
    flush[0] = 1'b1;
    #1;
    total++;
    if (div_flush !== 1'b1 || div_valid !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      bad++;
      $display("FAIL flush_busy: div_flush=%b div_valid=%b rsp_valid=%b req_ready=%b expected 1/0/00/00",
               div_flush, div_valid, rsp_valid, req_ready);
    end
    next_cycle();
    flush = 2'b00;
    div_done = 1'b1;
    div_res = $urandom;
    #1;
    total++;
    if (div_flush !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00 || div_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort: div_flush=%b rsp_valid=%b req_ready=%b div_valid=%b expected 0/00/00/0",
               div_flush, rsp_valid, req_ready, div_valid);
    end
    next_cycle();
    div_done = 1'b0;
    do_grant(w);
    do_complete(w, 2, -1);
  endtask

  task automatic test_flush_other();
    int w;
    gen_normal(0);
    pend = 2'b01;
    do_grant(w);
    do_complete(w, 4, 1);
  endtask

  task automatic test_reset_mid();
    int w;
    gen_normal(0);
    pend = 2'b01;
    do_grant(w);
    next_cycle();
    reset = 1'b0;
    #1;
    total++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || div_valid !== 1'b0 || div_flush !== 1'b0 ||
        rsp_data !== 32'd0 || div_a !== 32'd0 || div_b !== 32'd0 || div_funct3 !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid: rdy=%b rv=%b dv=%b df=%b rd=%h a=%h b=%h f3=%b expected all zero",
               req_ready, rsp_valid, div_valid, div_flush, rsp_data, div_a, div_b, div_funct3);
    end
    next_cycle();
    next_cycle();
    reset = 1'b1;
    ptr_m = 0;
    last_rsp = 32'd0;
    gen_normal(0);
    gen_normal(1);
    do_grant(w);
    do_complete(w, 2, -1);
  endtask

  task automatic test_random();
    int w;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) gen_any(i);
      if (pend == 2'b00) gen_any(0);
      do_grant(w);
      do_complete(w, $urandom_range(0, 4), -1);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_fast();
    test_fast_flush();
    test_back_to_back();
    test_flush_owner();
    test_flush_other();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
DIV_SHARE_CTRL -- requirements
Module: div_share_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requester ports (fixed at 2 in this revision).
REQ-002 SHALL have ports clk input 1 (clock) and reset input 1, asynchronous, active-low.
REQ-003 SHALL have ports req_valid input [1:0], per-requester operation request, held until accepted.
REQ-004 SHALL have ports req_a and req_b, input [1:0][31:0], dividend and divisor per requester.
REQ-005 SHALL have port req_funct3 input [1:0][2:0], RISC-V M funct3 per requester: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port req_ready output [1:0], one-cycle accept pulse per requester.
REQ-007 SHALL have port flush input [1:0], per-requester cancel of the owned operation.
REQ-008 SHALL have ports rsp_valid output [1:0] (one-hot, one-cycle pulse) and rsp_data output [31:0] (result).
REQ-009 SHALL have divider-side ports div_valid, div_flush, div_a[31:0], div_b[31:0], div_funct3[2:0] (outputs), and div_res[31:0], div_done (inputs; div_done is a one-cycle pulse with div_res valid in the same cycle).

Function
REQ-010 SHALL implement states IDLE, FAST, ISSUE, BUSY, ABORT and RESP.
REQ-011 In IDLE, the controller SHALL grant one valid requester whose flush is low by round-robin, pulse its req_ready, and register its operands, funct3 and owner id.
REQ-012 The round-robin pointer SHALL point to the non-granted requester after each grant; the reset pointer SHALL be 0.
REQ-013 A grant SHALL go to FAST when b==0, or when the op is signed (funct3[0]==0) with a==0x80000000 and b==0xFFFFFFFF; otherwise it SHALL go to ISSUE.
REQ-014 FAST SHALL produce its result without the divider:
- b==0: quotient 0xFFFFFFFF, remainder a.
- overflow: quotient 0x80000000, remainder 0.
FAST SHALL pulse rsp_valid[owner] and then return to IDLE.
REQ-015 In ISSUE, div_valid SHALL be 1 for exactly one cycle, with div_a, div_b and div_funct3 driven from the registers; the state SHALL then go to BUSY.
REQ-016 In BUSY, on div_done, the controller SHALL capture div_res and go to RESP.
REQ-017 RESP SHALL pulse rsp_valid[owner] with rsp_data equal to the captured value, then return to IDLE.
REQ-018 Latency SHALL be:
- fast path: accept at cycle T, rsp_valid at T+1.
- normal path: accept T, div_valid T+1, div_done at D, rsp_valid at D+1.
REQ-019 When flush[owner] is asserted in ISSUE or BUSY, the controller SHALL drive div_flush=1 for one cycle, enter ABORT, and return to IDLE on the next cycle.
REQ-020 div_done arriving in the flush cycle or in ABORT SHALL be discarded, with no rsp_valid.
REQ-021 When flush[owner] is asserted in FAST or RESP, rsp_valid SHALL be suppressed.
REQ-022 flush of the non-owner SHALL have no effect on the in-flight operation.
REQ-023 No new grant SHALL be issued outside IDLE, so at most one operation is outstanding.
REQ-024 rsp_data SHALL hold its last value when rsp_valid is 0.
REQ-025 div_valid and div_flush SHALL never be high in the same cycle.

Reset
REQ-026 On reset low, the block SHALL asynchronously enter IDLE.
REQ-027 On reset low, req_ready, rsp_valid, div_valid and div_flush SHALL be 0, and rsp_data, the operand registers, the owner id and the pointer SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL abandon the operation without any response; the divider is reset by the same signal.

Structure
REQ-029 Package div_share_pkg SHALL hold:
- the state enum;
- the funct3 constants F3_DIV, F3_DIVU, F3_REM, F3_REMU;
- DIV0_QUOT=0xFFFFFFFF, INT_MIN=0x80000000, NEG_ONE=0xFFFFFFFF.
REQ-030 The grant logic SHALL be a sub-module rr_arbiter2 (request[1:0], advance, grant[1:0], with a registered pointer); everything else stays in div_share_ctrl.

Verification
REQ-031 Req0 DIV a=100 b=7 alone -> req_ready[0] at T, div_valid at T+1; after div_done with div_res=14, rsp_valid[0] with rsp_data=14 one cycle later.
REQ-032 Req1 REM a=0xFFFFFFF9 (-7) b=0 -> no div_valid; rsp_valid[1] at T+1 with rsp_data=0xFFFFFFF9. Req0 DIV a=0x80000000 b=0xFFFFFFFF -> rsp_data=0x80000000 at T+1.
REQ-033 Both requesters held valid continuously with normal-path ops -> grants alternate 0,1,0,1, and exactly one div_valid precedes each rsp_valid.
REQ-034 Req0 DIVU issued, flush[0] pulsed in BUSY -> div_flush one cycle, a div_done injected during ABORT is ignored, no rsp_valid; the next pending req1 is granted the following cycle.
REQ-035 flush[1] pulsed while req0 is in BUSY -> no div_flush, and req0 completes normally.
REQ-036 reset driven low in BUSY -> all outputs 0 immediately; after release, a fresh request completes with correct latency and the pointer restarts at 0.
